// File: rtl/kernel_window_buffer.sv
// 5x5 sliding-window generator over a raster-order AXI-Stream pixel input.
// Optional tlast line-length checking is enabled by defining KERNEL_WINDOW_LINE_CHECK_EN.
module kernel_window_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 512
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_s_axis_tdata,
  input  logic                  i_s_axis_tvalid,
  input  logic                  i_s_axis_tuser,
  input  logic                  i_s_axis_tlast,
  output logic                  o_s_axis_tready,
  output logic [DATA_WIDTH-1:0] o_image_kernel_buffer [0:4][0:4],
  output logic                  o_kernel_valid,
  output logic                  o_kernel_sof,
  output logic                  o_kernel_eol,
  output logic                  o_line_err
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int LW = (KERNEL_SIZE - 1) * DATA_WIDTH;
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(KERNEL_SIZE - 2);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t        state_reg;
  state_t        st;
  logic [CW-1:0] col_reg;
  logic [CW-1:0] x;
  logic [RW-1:0] row_reg;
  logic [RW-1:0] y;
  logic          accept;
  logic          proc;
  logic          emit;
  logic          at_last_col;
  logic          line_end;
  logic          valid_reg;
  logic          sof_reg;
  logic          eol_reg;

  // One word per column holds LB1 in the low slice up to LB4 in the high slice.
  logic [LW-1:0] lb_mem [0:IMG_WIDTH-1];
  logic [LW-1:0] lb_rd;
  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] col_in;
  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win_reg;

  assign o_s_axis_tready = !i_reset;
  assign accept = i_s_axis_tvalid && o_s_axis_tready;

  // A tuser beat restarts the frame and is itself treated as pixel (0, 0).
  assign proc        = accept && (i_s_axis_tuser || (state_reg != IDLE));
  assign st          = i_s_axis_tuser ? FILL : state_reg;
  assign x           = i_s_axis_tuser ? '0 : col_reg;
  assign y           = i_s_axis_tuser ? '0 : row_reg;
  assign at_last_col = (x == COL_LAST);
  assign emit        = (st == STREAM) && (x >= COL_FIRST_WIN);
  assign lb_rd       = lb_mem[x];

`ifdef KERNEL_WINDOW_LINE_CHECK_EN
  logic err_reg;
  assign line_end   = at_last_col || i_s_axis_tlast;
  assign o_line_err = err_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_reg <= 1'b0;
    end else if (proc && (i_s_axis_tlast != at_last_col)) begin
      err_reg <= 1'b1;
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = i_s_axis_tlast;
  assign line_end     = at_last_col;
  assign o_line_err   = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (proc) begin
      lb_mem[x] <= {lb_rd[LW-DATA_WIDTH-1:0], i_s_axis_tdata};
    end
  end

  // Row 0 of the new column is the oldest line (LB4); the bottom row is the live pixel.
  for (genvar gi = 0; gi < KERNEL_SIZE - 1; gi++) begin : g_col_in
    assign col_in[gi] = lb_rd[(KERNEL_SIZE-1-gi)*DATA_WIDTH-1 -: DATA_WIDTH];
  end
  assign col_in[KERNEL_SIZE-1] = i_s_axis_tdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      win_reg <= '0;
    end else if (proc) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
          win_reg[r][c] <= win_reg[r][c+1];
        end
        win_reg[r][KERNEL_SIZE-1] <= col_in[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        o_image_kernel_buffer[r][c] = win_reg[r][c];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      valid_reg <= 1'b0;
      sof_reg   <= 1'b0;
      eol_reg   <= 1'b0;
    end else begin
      valid_reg <= proc && emit;
      sof_reg   <= proc && emit && (y == ROW_FIRST_WIN) && (x == COL_FIRST_WIN);
      eol_reg   <= proc && emit && at_last_col;
      if (proc) begin
        if (line_end) begin
          col_reg <= '0;
          row_reg <= (y == ROW_LAST) ? '0 : y + RW'(1);
        end else begin
          col_reg <= x + CW'(1);
          row_reg <= y;
        end
        case (st)
          FILL:    state_reg <= (y == ROW_FILL_LAST && line_end) ? STREAM : FILL;
          STREAM:  state_reg <= (y == ROW_LAST && line_end) ? IDLE : STREAM;
          default: state_reg <= st;
        endcase
      end
    end
  end

  assign o_kernel_valid = valid_reg;
  assign o_kernel_sof   = sof_reg;
  assign o_kernel_eol   = eol_reg;

endmodule

// File: tb/tb_kernel_window_buffer.sv
// Self-checking bench for kernel_window_buffer on an 8x6 image with pixel = (row<<4)|col.
// Windows are predicted from a stored copy of the frame, indexed by frame coordinates.
module tb_kernel_window_buffer;
  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] tdata = '0;
  logic       tvalid = 1'b0;
  logic       tuser = 1'b0;
  logic       tlast = 1'b0;
  logic       tready;
  logic [7:0] win [0:4][0:4];
  logic       kvalid;
  logic       ksof;
  logic       keol;
  logic       line_err;

  kernel_window_buffer #(
    .DATA_WIDTH(8), .KERNEL_SIZE(5), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_s_axis_tdata(tdata),
    .i_s_axis_tvalid(tvalid),
    .i_s_axis_tuser(tuser),
    .i_s_axis_tlast(tlast),
    .o_s_axis_tready(tready),
    .o_image_kernel_buffer(win),
    .o_kernel_valid(kvalid),
    .o_kernel_sof(ksof),
    .o_kernel_eol(keol),
    .o_line_err(line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         y;
    int         x;
    bit         v;
    bit         sof;
    bit         eol;
    logic [7:0] c00;
    logic [7:0] c22;
    logic [7:0] c44;
  } vec_t;

  vec_t tbl [7];

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  bit chk_win  = 1'b1;

  // Reference model: frame-coordinate position plus a stored image.
  logic [7:0] img [0:H-1][0:W-1];
  bit m_active = 1'b0;
  bit m_err    = 1'b0;
  int m_y = 0;
  int m_x = 0;

  function automatic logic [7:0] pix(input int y, input int x);
    return 8'((y << 4) | x);
  endfunction

  function automatic logic [199:0] dut_win();
    logic [199:0] w;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[(r*5+c)*8 +: 8] = win[r][c];
    return w;
  endfunction

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input bit u, input bit l, input logic [7:0] d, input bit rst);
    bit           emit;
    bit           e_sof;
    bit           e_eol;
    bit           leol;
    int           ey;
    int           ex;
    logic [199:0] exp_w;
    emit = 0; e_sof = 0; e_eol = 0; ey = 0; ex = 0; exp_w = '0;
    @(negedge clk);
    i_reset = rst; tvalid = v; tuser = u; tlast = l; tdata = d;
    #1;
    check("tready", 200'(tready), 200'(!rst));
    if (rst) begin
      m_active = 0;
      m_err    = 0;
    end else if (v) begin
      if (u) begin
        m_active = 1; m_y = 0; m_x = 0;
      end
      if (m_active) begin
        img[m_y][m_x] = d;
        if (m_y >= 4 && m_x >= 4) begin
          emit  = 1;
          e_sof = (m_y == 4 && m_x == 4);
          e_eol = (m_x == W - 1);
          ey = m_y; ex = m_x;
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              exp_w[(r*5+c)*8 +: 8] = img[m_y-4+r][m_x-4+c];
        end
        leol = (m_x == W - 1);
`ifdef KERNEL_WINDOW_LINE_CHECK_EN
        if (l != leol) m_err = 1;
        leol = leol || l;
`endif
        if (leol) begin
          m_x = 0;
          if (m_y == H - 1) m_active = 0;
          else m_y++;
        end else begin
          m_x++;
        end
      end
    end
    @(posedge clk);
    #1;
    check("kernel_valid", 200'(kvalid), 200'(emit));
    check("line_err", 200'(line_err), 200'(m_err));
    if (kvalid) begin
      pulses++;
      $display("window at (%0d,%0d): c00=%02h c22=%02h c44=%02h sof=%0b eol=%0b",
               ey, ex, win[0][0], win[2][2], win[4][4], ksof, keol);
    end
    if (emit) begin
      check("kernel_sof", 200'(ksof), 200'(e_sof));
      check("kernel_eol", 200'(keol), 200'(e_eol));
      if (chk_win) check("window", dut_win(), exp_w);
    end
    if (rst) begin
      check("reset_window", dut_win(), '0);
      check("reset_sof", 200'(ksof), '0);
      check("reset_eol", 200'(keol), '0);
    end
  endtask

  // Sends frame beats in raster order, stopping just before (stop_y, stop_x).
  task automatic send_frame(input bit gaps, input bit use_tbl, input int stop_y, input int stop_x);
    int g;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == stop_y && x == stop_x) return;
        g = 0;
        while (gaps && g < 6 && $urandom_range(0, 99) < 50) begin
          step(0, $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom), 0);
          g++;
        end
        step(1, (y == 0 && x == 0), (x == W - 1), pix(y, x), 0);
        if (use_tbl) begin
          for (int i = 0; i < 7; i++) begin
            if (tbl[i].y == y && tbl[i].x == x) begin
              check("tbl_valid", 200'(kvalid), 200'(tbl[i].v));
              if (tbl[i].v) begin
                check("tbl_sof", 200'(ksof), 200'(tbl[i].sof));
                check("tbl_eol", 200'(keol), 200'(tbl[i].eol));
                check("tbl_c00", 200'(win[0][0]), 200'(tbl[i].c00));
                check("tbl_c22", 200'(win[2][2]), 200'(tbl[i].c22));
                check("tbl_c44", 200'(win[4][4]), 200'(tbl[i].c44));
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{3, 7, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{4, 3, 0, 0, 0, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{4, 4, 1, 1, 0, 8'h00, 8'h22, 8'h44};
    tbl[4] = '{4, 7, 1, 0, 1, 8'h03, 8'h25, 8'h47};
    tbl[5] = '{5, 5, 1, 0, 0, 8'h11, 8'h33, 8'h55};
    tbl[6] = '{5, 7, 1, 0, 1, 8'h13, 8'h35, 8'h57};

    // Reset state, then first cycle out of reset.
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 0);

    // Full frame, continuous tvalid.
    pulses = 0;
    send_frame(0, 1, -1, -1);
    check("pulses_continuous", 200'(pulses), 200'(8));

    // Same frame with random tvalid gaps.
    pulses = 0;
    send_frame(1, 1, -1, -1);
    check("pulses_gaps", 200'(pulses), 200'(8));

    // Beats before any tuser are dropped.
    pulses = 0;
    for (int i = 0; i < 5; i++) step(1, 0, $urandom_range(0, 1), 8'($urandom), 0);
    check("pulses_pre_tuser", 200'(pulses), 200'(0));
    send_frame(0, 1, -1, -1);
    check("pulses_after_pre_tuser", 200'(pulses), 200'(8));

    // tuser reasserted at (3, 2) aborts the frame.
    pulses = 0;
    send_frame(0, 0, 3, 2);
    check("pulses_aborted", 200'(pulses), 200'(0));
    send_frame(0, 0, -1, -1);
    check("pulses_restarted", 200'(pulses), 200'(8));

    // Reset pulsed at (4, 6); leftover beats without tuser produce nothing.
    pulses = 0;
    send_frame(0, 0, 4, 6);
    check("pulses_before_reset", 200'(pulses), 200'(2));
    step(1, 0, 0, pix(4, 6), 1);
    step(1, 0, 0, pix(4, 6), 1);
    pulses = 0;
    step(1, 0, 0, pix(4, 6), 0);
    step(1, 0, 1, pix(4, 7), 0);
    for (int x = 0; x < W; x++) step(1, 0, (x == W - 1), pix(5, x), 0);
    check("pulses_after_reset_no_tuser", 200'(pulses), 200'(0));
    send_frame(0, 0, -1, -1);
    check("pulses_after_reset_frame", 200'(pulses), 200'(8));

    // Early tlast at column 5 of row 1.
    step(0, 0, 0, 8'h00, 1);
    chk_win = 0;
    pulses = 0;
    for (int x = 0; x < W; x++) step(1, (x == 0), (x == W - 1), pix(0, x), 0);
    for (int x = 0; x < 6; x++) step(1, 0, (x == 5), pix(1, x), 0);
`ifdef KERNEL_WINDOW_LINE_CHECK_EN
    check("line_err_early_tlast", 200'(line_err), 200'(1));
`else
    check("line_err_early_tlast", 200'(line_err), 200'(0));
`endif
    for (int k = 0; k < 3 * W; k++) step(1, 0, ((k % W) == W - 1), pix(2 + k / W, k % W), 0);
`ifdef KERNEL_WINDOW_LINE_CHECK_EN
    check("pulses_line_check", 200'(pulses), 200'(4));
`else
    check("pulses_line_check", 200'(pulses), 200'(2));
`endif
    chk_win = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/kernel_window_buffer.md
# kernel_window_buffer

- Builds the 5×5 pixel neighbourhood from a raster-order AXI-Stream pixel input, using four line buffers and a 5×5 shift window.
- Presents each complete window as a parallel array with a one-cycle valid strobe.
- Sits directly upstream of the per-row/per-column sorting stage of the 5×5 median filter and drives its `i_image_kernel_buffer` input.
- Emits only windows fully inside the image; there is no border padding.

## Interface
- `DATA_WIDTH`, 8: pixel width in bits.
- `KERNEL_SIZE`, 5: window dimension; only 5 is supported.
- `IMG_WIDTH`, 640: pixels per line; must be ≥ 5.
- `IMG_HEIGHT`, 512: lines per frame; must be ≥ 5.
- `i_clk` in 1: sole clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_s_axis_tdata` in DATA_WIDTH: pixel.
- `i_s_axis_tvalid` in 1: pixel valid.
- `i_s_axis_tuser` in 1: start of frame, on the first pixel.
- `i_s_axis_tlast` in 1: end of line.
- `o_s_axis_tready` out 1: input ready.
- `o_image_kernel_buffer` out [DATA_WIDTH-1:0] [0:4][0:4]: window; [r][c], r=0 oldest line, c=0 oldest column.
- `o_kernel_valid` out 1: window valid, one-cycle strobe per emitted window.
- `o_kernel_sof` out 1: first window of a frame; qualified by `o_kernel_valid`.
- `o_kernel_eol` out 1: last window of a line; qualified by `o_kernel_valid`.
- `o_line_err` out 1: sticky line-length error; used only with the macro.

## Operation
- **Beat acceptance:** a beat is accepted when `i_s_axis_tvalid && o_s_axis_tready`. `o_s_axis_tready` is 1 in every cycle except during reset. There is no output back-pressure; downstream stages are fixed-latency.
- **Counters:**
  - `col` runs 0..IMG_WIDTH-1, width `$clog2(IMG_WIDTH)`, and wraps to 0 with `row+1`.
  - `row` runs 0..IMG_HEIGHT-1.
  - Both counters advance only on accepted beats.
- **Line buffers** LB1..LB4 are IMG_WIDTH-deep arrays. On an accepted beat at column x:
  - Read LB1..LB4[x] before writing.
  - Write LB1[x] ← pixel, LB2[x] ← old LB1[x], LB3[x] ← old LB2[x], LB4[x] ← old LB3[x].
  - Line buffer contents are not reset.
- **Window shift:** on every accepted beat, columns 0..3 ← columns 1..4. The new column 4 is:
  - r0 = LB4[x]
  - r1 = LB3[x]
  - r2 = LB2[x]
  - r3 = LB1[x]
  - r4 = pixel
- **FSM states:**
  - **IDLE:** after reset. Accepted beats without tuser are dropped, with no counter or buffer update. A tuser beat moves to FILL and is processed as (row 0, col 0).
  - **FILL:** row < 4. Line buffers and window update; no windows are emitted. The beat at (3, IMG_WIDTH-1) moves to STREAM.
  - **STREAM:** an accepted beat with col ≥ 4 emits a window. The beat at (IMG_HEIGHT-1, IMG_WIDTH-1) emits its window and moves to IDLE.
- **Centre pixel:** a window emitted for beat (y, x) has centre [2][2] = pixel (y-2, x-2) and [4][4] = pixel (y, x).
- **Mid-frame tuser:** a tuser beat in any state aborts the current frame. The FSM enters FILL, and the beat is processed as (0, 0).
- **Output flags:**
  - `o_kernel_sof` = 1 for the window at (4, 4).
  - `o_kernel_eol` = 1 for windows at col = IMG_WIDTH-1.

## Timing
- Latency is 1 cycle: a window-producing beat accepted in cycle n gives `o_kernel_valid` = 1 and the updated window in cycle n+1.
- `o_kernel_valid`, `o_kernel_sof` and `o_kernel_eol` are single-cycle strobes.
- `o_image_kernel_buffer` holds its value between accepted beats.
- tvalid gaps stall all state; no window is emitted during a gap.
- Reset values:
  - `o_s_axis_tready` = 0 while `i_reset`=1; it is 1 in the first cycle after `i_reset` falls.
  - Window = 0; all strobes = 0; `o_line_err` = 0.
  - FSM = IDLE; counters = 0.
- A reset asserted mid-frame discards the frame at the next clock edge. The next frame must begin with tuser.
- Windows per frame = (IMG_WIDTH-4)·(IMG_HEIGHT-4).

## Configuration
- **`KERNEL_WINDOW_LINE_CHECK_EN` defined:**
  - tlast is checked against `col`.
  - If tlast arrives at col ≠ IMG_WIDTH-1, `o_line_err` sets; the beat is processed normally, then col ← 0 and row increments.
  - If col = IMG_WIDTH-1 arrives without tlast, `o_line_err` sets and the counters wrap normally.
  - `o_line_err` is sticky until `i_reset`.
- **Macro undefined:** tlast is ignored, the counters wrap on IMG_WIDTH only, and `o_line_err` is tied to 0.

## Test plan
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6 and pixel = (row<<4) | col.

- **Full frame, continuous tvalid:** exactly 8 `o_kernel_valid` pulses. The first pulse has [0][0]=0x00, [2][2]=0x22, [4][4]=0x44 and `o_kernel_sof`=1. The last pulse has [4][4]=0x57 and `o_kernel_eol`=1.
- **Random 50% tvalid gaps:** window sequence and values are identical to the continuous case, with each valid pulse exactly 1 cycle after its accepted beat.
- **Beats before the first tuser, then a tuser frame:** pre-tuser beats produce no windows. The tuser frame matches the first scenario.
- **tuser reasserted at (3, 2):** no windows come from the aborted frame. The new frame's first window appears 1 cycle after its beat (4, 4).
- **`i_reset` pulsed at (4, 6):** `o_s_axis_tready`=0 during reset, all outputs are 0 in the cycle after reset, and no window is emitted until a new tuser frame reaches (4, 4).
- **Macro defined, tlast at col 5 of row 1:** `o_line_err`=1 from the next cycle onward, and the next beat is counted as (2, 0). With the macro undefined, `o_line_err` stays 0.
